// File: rtl/i2s_adc_rx_if.sv
// Frame handshake between the I2S receiver (master) and its downstream consumer (slave).
`timescale 1ns/1ps
interface i2s_adc_rx_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] data_l;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  frame_valid;
    logic                  frame_ready;
    logic                  overrun;
    logic                  overrun_clr;

    modport master (
        output data_l, data_r, frame_valid, overrun,
        input  frame_ready, overrun_clr
    );

    modport slave (
        input  data_l, data_r, frame_valid, overrun,
        output frame_ready, overrun_clr
    );
endinterface

// File: rtl/i2s_adc_rx.sv
// I2S / left-justified ADC receiver master: generates MCLK/SCLK/LRCK from clk and
// deserialises SDOUT into stereo frames offered on a valid/ready handshake.
`timescale 1ns/1ps
module i2s_adc_rx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_BITS  = 32,
    parameter int SCLK_DIV   = 4,
    parameter int JUSTIFY    = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sdout_adc,
    output logic         mclk_adc,
    output logic         sclk_adc,
    output logic         lrck_adc,
    i2s_adc_rx_if.master frm
);
    localparam int OFF   = (JUSTIFY == 0) ? 1 : 0;
    localparam int PH_W  = $clog2(SCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_BITS);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SCLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(SCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_N   = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] K_FIRST  = BIT_W'(OFF);
    localparam logic [BIT_W-1:0] K_LAST   = BIT_W'(OFF + DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] WORD_N   = BIT_W'(DATA_WIDTH);

    // Frame counter held as (bit index, phase): cnt = bit_q * SCLK_DIV + ph_q.
    logic [PH_W-1:0]       ph_q, ph_p0;
    logic [BIT_W-1:0]      bit_q, bit_p0, slot_k_p0;
    logic                  lrck_p0, sample_p0, in_word_p0, last_p0;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] sh_l, sh_r;

    assign mclk_adc = clk;

    always_comb begin
        ph_p0  = '0;
        bit_p0 = '0;
        if (en) begin
            if (ph_q == PH_LAST) begin
                ph_p0  = '0;
                bit_p0 = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
            end else begin
                ph_p0  = ph_q + PH_W'(1);
                bit_p0 = bit_q;
            end
        end
    end

    // Stage p0: decode of the count value being entered on this edge.
    assign lrck_p0    = (bit_p0 >= SLOT_N);
    assign slot_k_p0  = lrck_p0 ? (bit_p0 - SLOT_N) : bit_p0;
    assign sample_p0  = en && (ph_p0 == PH_HALF);
    // Unsigned wrap makes slot bits below the offset compare as out of range.
    assign in_word_p0 = ((slot_k_p0 - K_FIRST) < WORD_N);
    assign last_p0    = sample_p0 && lrck_p0 && (slot_k_p0 == K_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph_q     <= '0;
            bit_q    <= '0;
            sclk_adc <= 1'b0;
            lrck_adc <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            ph_q     <= ph_p0;
            bit_q    <= bit_p0;
            sclk_adc <= (ph_p0 >= PH_HALF);
            lrck_adc <= lrck_p0;
            vld_p1   <= last_p0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_l <= '0;
            sh_r <= '0;
        end else if (!en) begin
            sh_l <= '0;
            sh_r <= '0;
        end else if (sample_p0 && in_word_p0) begin
            if (lrck_p0)
                sh_r <= {sh_r[DATA_WIDTH-2:0], sdout_adc};
            else
                sh_l <= {sh_l[DATA_WIDTH-2:0], sdout_adc};
        end
    end

    // Stage p1: frame completes one edge after the right-channel LSB is captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frm.data_l      <= '0;
            frm.data_r      <= '0;
            frm.frame_valid <= 1'b0;
            frm.overrun     <= 1'b0;
        end else begin
            if (vld_p1) begin
                frm.data_l      <= sh_l;
                frm.data_r      <= sh_r;
                frm.frame_valid <= 1'b1;
            end else if (frm.frame_valid && frm.frame_ready) begin
                frm.frame_valid <= 1'b0;
            end
            frm.overrun <= (vld_p1 && frm.frame_valid && !frm.frame_ready) ||
                           (frm.overrun && !frm.overrun_clr);
        end
    end
endmodule
